// File: rtl/sn_reg_decoder_if.sv
// CPU write bus and decoded register outputs of the SN76489-style PSG write decoder.
// master: CPU / bench side (drives we_n and data). slave: the decoder.
interface sn_reg_decoder_if;
    logic       we_n;
    logic [7:0] data;
    logic       ready;
    logic [9:0] tone0;
    logic [9:0] tone1;
    logic [9:0] tone2;
    logic [3:0] atten0;
    logic [3:0] atten1;
    logic [3:0] atten2;
    logic [3:0] atten3;
    logic       noise_mode;
    logic [1:0] noise_sel;
    logic       noise_rst;

    modport master (
        output we_n, data,
        input  ready, tone0, tone1, tone2, atten0, atten1, atten2, atten3,
               noise_mode, noise_sel, noise_rst
    );

    modport slave (
        input  we_n, data,
        output ready, tone0, tone1, tone2, atten0, atten1, atten2, atten3,
               noise_mode, noise_sel, noise_rst
    );
endinterface

// File: rtl/sn_reg_decoder.sv
// SN76489-style PSG write decoder: latch/data byte protocol into tone, attenuation
// and noise-control registers, with a fixed READY busy window after each write.
// Optional macro SN_WE_SYNC_EN: adds a 2-flop synchronizer on we_n (accept 2 cycles later).
module sn_reg_decoder #(
    parameter int unsigned READY_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    sn_reg_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            we_in;
    logic            we_q;
    logic            accept;
    logic [7:0]      data_q, data_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [2:0][9:0] tone_q, tone_d;
    logic [3:0][3:0] atten_q, atten_d;
    logic            mode_q, mode_d;
    logic [1:0]      sel_q, sel_d;
    logic            nrst_q, nrst_d;
    logic [1:0]      chan_q, chan_d;
    logic            type_q, type_d;
    logic [1:0]      w_chan;
    logic            w_type;

`ifdef SN_WE_SYNC_EN
    logic we_s1_q, we_s2_q;

    // Two-stage synchronizer for an asynchronous CPU write strobe (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_s1_q <= 1'b1;
            we_s2_q <= 1'b1;
        end else begin
            we_s1_q <= bus.we_n;
            we_s2_q <= we_s1_q;
        end
    end

    assign we_in = we_s2_q;
`else
    assign we_in = bus.we_n;
`endif

    // A write is a falling edge of the strobe seen while idle; edges while busy are dropped
    assign accept = (state_q == IDLE) && we_q && !we_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = APPLY;
            APPLY:   state_d = BUSY;
            BUSY:    if (cnt_q == 8'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: capture on accept, decode in APPLY, count down in BUSY
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        tone_d  = tone_q;
        atten_d = atten_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        nrst_d  = 1'b0;
        chan_d  = chan_q;
        type_d  = type_q;
        // a latch byte selects the target for itself as well as for later data bytes
        w_chan  = data_q[7] ? data_q[6:5] : chan_q;
        w_type  = data_q[7] ? data_q[4]   : type_q;
        case (state_q)
            IDLE: begin
                if (accept) data_d = bus.data;
            end
            APPLY: begin
                ready_d = 1'b0;
                cnt_d   = 8'(READY_CYCLES);
                chan_d  = w_chan;
                type_d  = w_type;
                if (w_type) begin
                    atten_d[w_chan] = data_q[3:0];
                end else if (w_chan == 2'd3) begin
                    mode_d = data_q[2];
                    sel_d  = data_q[1:0];
                    nrst_d = 1'b1;
                end else if (data_q[7]) begin
                    tone_d[w_chan][3:0] = data_q[3:0];
                end else begin
                    tone_d[w_chan][9:4] = data_q[5:0];
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b1;
            data_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            tone_q  <= '0;
            atten_q <= '1;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            nrst_q  <= 1'b0;
            chan_q  <= '0;
            type_q  <= 1'b0;
        end else begin
            we_q    <= we_in;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            tone_q  <= tone_d;
            atten_q <= atten_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            nrst_q  <= nrst_d;
            chan_q  <= chan_d;
            type_q  <= type_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.tone0      = tone_q[0];
    assign bus.tone1      = tone_q[1];
    assign bus.tone2      = tone_q[2];
    assign bus.atten0     = atten_q[0];
    assign bus.atten1     = atten_q[1];
    assign bus.atten2     = atten_q[2];
    assign bus.atten3     = atten_q[3];
    assign bus.noise_mode = mode_q;
    assign bus.noise_sel  = sel_q;
    assign bus.noise_rst  = nrst_q;

endmodule
